// File: rtl/gyruss_snd_post.sv
// gyruss_snd_post - stereo output conditioner after the Gyruss sound mixer.
//
// Captures an unsigned 16-bit L/R mixer sample on SMPEN, removes its DC
// offset with a per-channel leaky integrator, scales it by a ramped master
// gain and emits saturated signed 16-bit PCM. One six-state sequencer
// time-multiplexes a single DC tracker and a single multiplier over both
// channels.
//
// Ports:
//   MCLK       in   system clock, all state on the rising edge
//   RESET      in   asynchronous, active-high reset
//   SMPEN      in   sample strobe (one MCLK wide)
//   IN_L/IN_R  in   unsigned 16-bit mixer samples
//   VOL        in   master volume, target gain = {VOL,VOL}
//   MUTE       in   forces target gain to zero
//   OUT_L/R    out  signed 16-bit PCM, held between OUT_VLD pulses
//   OUT_VLD    out  one-cycle pulse when OUT_L/OUT_R update
//   BUSY       out  sequencer not idle
//   OVR        out  one-cycle pulse when a strobe was dropped
//   DBG_STATE  out  current sequencer state
//
// Handshake: SMPEN is a valid-only strobe with no backpressure. It is taken
// when the sequencer is IDLE, or in OUT (the last step of the previous
// sample, giving one sample per 5 MCLK). A strobe during DCL..MULR is
// dropped and flagged on OVR. OUT_VLD is likewise valid-only: the consumer
// must take OUT_L/OUT_R in the cycle it is high.

module gyruss_snd_post #(
   parameter int DCK       = 10,
   parameter int RAMP_STEP = 1
) (
   input  logic        MCLK,
   input  logic        RESET,
   input  logic        SMPEN,
   input  logic [15:0] IN_L,
   input  logic [15:0] IN_R,
   input  logic [3:0]  VOL,
   input  logic        MUTE,
   output logic [15:0] OUT_L,
   output logic [15:0] OUT_R,
   output logic        OUT_VLD,
   output logic        BUSY,
   output logic        OVR,
   output logic [2:0]  DBG_STATE
);

   localparam int AW = 16 + DCK;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_DCL  = 3'd1,
      S_DCR  = 3'd2,
      S_MULL = 3'd3,
      S_MULR = 3'd4,
      S_OUT  = 3'd5
   } state_t;

   state_t              state_q;
   logic [15:0]         x_l_q, x_r_q;
   logic [AW-1:0]       acc_l_q, acc_r_q;
   logic signed [16:0]  y_l_q, y_r_q;
   logic [15:0]         s_l_q, s_r_q;
   logic [15:0]         out_l_q, out_r_q;
   logic                out_vld_q, ovr_q;
   logic [7:0]          g_q;

   logic [15:0]         dc_x, dc_val;
   logic [AW-1:0]       dc_acc, acc_d;
   logic [AW:0]         dc_sum;
   logic signed [16:0]  y_d;
   logic signed [16:0]  mul_y;
   logic signed [25:0]  mul_p;
   logic signed [17:0]  mul_s;
   logic [15:0]         sat_d;
   logic [7:0]          tgt;
   logic [8:0]          g_up, g_dn;
   logic [7:0]          g_d;

   // Shared DC tracker: DCR works on the right channel, everything else left.
   always_comb begin
      dc_x   = (state_q == S_DCR) ? x_r_q   : x_l_q;
      dc_acc = (state_q == S_DCR) ? acc_r_q : acc_l_q;
      dc_val = dc_acc[AW-1:DCK];
      y_d    = signed'({1'b0, dc_x}) - signed'({1'b0, dc_val});
      // acc >= dc always, so acc + x - dc never goes negative; one guard bit
      // covers the transient acc + x.
      dc_sum = {1'b0, dc_acc} + {{(AW-15){1'b0}}, dc_x} - {{(AW-15){1'b0}}, dc_val};
      acc_d  = dc_sum[AW-1:0];
   end

   // Shared multiplier: floor(y * g / 256) saturated to signed 16 bits.
   always_comb begin
      mul_y = (state_q == S_MULR) ? y_r_q : y_l_q;
      mul_p = mul_y * signed'({1'b0, g_q});
      mul_s = mul_p[25:8];
      if (mul_s > 18'sd32767)
         sat_d = 16'h7FFF;
      else if (mul_s < -18'sd32768)
         sat_d = 16'h8000;
      else
         sat_d = mul_s[15:0];
   end

   // Gain ramp toward the target, clamped so it never overshoots.
   always_comb begin
      tgt  = MUTE ? 8'h00 : {VOL, VOL};
      g_up = {1'b0, g_q} + 9'(RAMP_STEP);
      g_dn = {1'b0, g_q} - 9'(RAMP_STEP);
      g_d  = g_q;
      if (g_q < tgt)
         g_d = (g_up > {1'b0, tgt}) ? tgt : g_up[7:0];
      else if (g_q > tgt)
         // bit 8 set means the subtraction went below zero
         g_d = (g_dn[8] || (g_dn[7:0] < tgt)) ? tgt : g_dn[7:0];
   end

   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         x_l_q     <= '0;
         x_r_q     <= '0;
         acc_l_q   <= '0;
         acc_r_q   <= '0;
         y_l_q     <= '0;
         y_r_q     <= '0;
         s_l_q     <= '0;
         s_r_q     <= '0;
         out_l_q   <= '0;
         out_r_q   <= '0;
         out_vld_q <= 1'b0;
         ovr_q     <= 1'b0;
         g_q       <= 8'h00;
      end else begin
         out_vld_q <= 1'b0;
         ovr_q     <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (SMPEN) begin
                  x_l_q   <= IN_L;
                  x_r_q   <= IN_R;
                  state_q <= S_DCL;
               end
            end
            S_DCL: begin
               y_l_q   <= y_d;
               acc_l_q <= acc_d;
               ovr_q   <= SMPEN;
               state_q <= S_DCR;
            end
            S_DCR: begin
               y_r_q   <= y_d;
               acc_r_q <= acc_d;
               ovr_q   <= SMPEN;
               state_q <= S_MULL;
            end
            S_MULL: begin
               s_l_q   <= sat_d;
               ovr_q   <= SMPEN;
               state_q <= S_MULR;
            end
            S_MULR: begin
               s_r_q   <= sat_d;
               ovr_q   <= SMPEN;
               state_q <= S_OUT;
            end
            S_OUT: begin
               out_l_q   <= s_l_q;
               out_r_q   <= s_r_q;
               out_vld_q <= 1'b1;
               g_q       <= g_d;
               // back-to-back strobe: the next sample starts right away
               if (SMPEN) begin
                  x_l_q   <= IN_L;
                  x_r_q   <= IN_R;
                  state_q <= S_DCL;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign OUT_L     = out_l_q;
   assign OUT_R     = out_r_q;
   assign OUT_VLD   = out_vld_q;
   assign OVR       = ovr_q;
   assign BUSY      = (state_q != S_IDLE);
   assign DBG_STATE = state_q;

endmodule
